// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
//   Shares one APB master between NUM_REQ requesters. A round-robin search
//   starting at ptr picks a winner in IDLE. The winner's command is latched
//   onto the S* outputs and handed to the master with a transfer request.
//   The APB bus is then watched until the access completes, and the read
//   data and error status go back to the winner with a one-cycle done pulse.
//
// Ports
//   PCLK, PRESET         clock, asynchronous active-high reset
//   req/req_write        per-requester request and direction (1 = write)
//   req_addr/req_wdata   per-requester 32-bit slices, slice i at [32i +: 32]
//   req_strb/req_prot    per-requester 4-bit strobes and 3-bit protection
//   gnt, done            one-hot grant, one-cycle completion pulse
//   rsp_err, rsp_rdata   PSLVERR / PRDATA captured at completion
//   SWRITE..SPROT        latched command to the APB master
//   transfer             start request to the APB master
//   PSEL..PRDATA         APB bus, observed only
module apb_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]  req_wdata,
    input  logic [NUM_REQ*4-1:0]   req_strb,
    input  logic [NUM_REQ*3-1:0]   req_prot,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic                   rsp_err,
    output logic [31:0]            rsp_rdata,
    output logic                   SWRITE,
    output logic [31:0]            SADDR,
    output logic [31:0]            SWDATA,
    output logic [3:0]             SSTRB,
    output logic [2:0]             SPROT,
    output logic                   transfer,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PREADY,
    input  logic                   PSLVERR,
    input  logic [31:0]            PRDATA
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] g;

    // Winner search and its command fields
    logic             found;
    logic [IDX_W-1:0] win;
    logic             sel_write;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic [3:0]       sel_strb;
    logic [2:0]       sel_prot;
    int unsigned      cand;

    // Scan NUM_REQ positions starting at ptr; the first set request wins.
    // Candidate index wraps without a modulo so non-power-of-two NUM_REQ works.
    always_comb begin
        found     = 1'b0;
        win       = '0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_strb  = '0;
        sel_prot  = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[IDX_W'(cand)]) begin
                found = 1'b1;
                win   = IDX_W'(cand);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (found && (32'(win) == i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*32 +: 32];
                sel_wdata = req_wdata[i*32 +: 32];
                sel_strb  = req_strb[i*4 +: 4];
                sel_prot  = req_prot[i*3 +: 3];
            end
        end
    end

    logic [IDX_W-1:0] ptr_next;
    assign ptr_next = (32'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            ptr       <= '0;
            g         <= '0;
            gnt       <= '0;
            done      <= '0;
            transfer  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            SWRITE    <= 1'b0;
            SADDR     <= '0;
            SWDATA    <= '0;
            SSTRB     <= '0;
            SPROT     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (found) begin
                        SWRITE   <= sel_write;
                        SADDR    <= sel_addr;
                        SWDATA   <= sel_wdata;
                        SSTRB    <= sel_strb;
                        SPROT    <= sel_prot;
                        gnt      <= '0;
                        gnt[win] <= 1'b1;
                        g        <= win;
                        transfer <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Master has entered SETUP; the request is consumed.
                    if (PSEL) begin
                        transfer <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (PSEL && PENABLE && PREADY) begin
                        done    <= '0;
                        done[g] <= 1'b1;
                        gnt     <= '0;
                        rsp_err <= PSLVERR;
                        rsp_rdata <= PRDATA;
                        ptr     <= ptr_next;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
